// File: rtl/tdm_channel_scanner_pkg.sv
// Shared types and helpers for the TDM channel scanner.
package tdm_channel_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tdm_channel_scanner_find.sv
// Priority finder over a skip mask: next unmasked index above cur, and lowest unmasked index.
module ch_next_find
    import tdm_channel_scanner_pkg::*;
#(
    parameter int N     = 16,
    parameter int SEL_W = clog2(N)
) (
    input  logic [N-1:0]     mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] nxt,
    output logic             nxt_found,
    output logic [SEL_W-1:0] low,
    output logic             low_found
);

    // Descending walk so the last hit written is the lowest qualifying index.
    always_comb begin
        nxt       = '0;
        nxt_found = 1'b0;
        low       = '0;
        low_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!mask[i]) begin
                low       = SEL_W'(i);
                low_found = 1'b1;
                if (i > int'(cur)) begin
                    nxt       = SEL_W'(i);
                    nxt_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tdm_channel_scanner.sv
// N:1 channel selector with registered valid/ready output; manual mux or auto-scan over unmasked channels.
//   state | meaning
//   IDLE  | manual mux (mode=0) or waiting for start (mode=1)
//   SCAN  | loading unmasked channels in ascending order
//   DRAIN | last sample of a one-shot frame waiting for acceptance
module tdm_channel_scanner
    import tdm_channel_scanner_pkg::*;
#(
    parameter int W     = 4,
    parameter int N     = 16,
    parameter int SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N*W-1:0]   d_in,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N-1:0]     skip_mask,
    input  logic             loop,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_done
);

    scan_state_t      state;
    logic [SEL_W-1:0] ptr;
    logic [N-1:0]     mask_q;
    logic             loop_q;

    logic [N-1:0]     find_mask;
    logic [SEL_W-1:0] nxt, low;
    logic             nxt_found, low_found;
    logic [W-1:0]     sel_data, ptr_data;
    logic             load, accept;

    assign load      = !out_valid || out_ready;
    assign accept    = out_valid && out_ready;
    // Live mask drives the start search; the latched one drives advance and wrap.
    assign find_mask = (state == IDLE) ? skip_mask : mask_q;

    ch_next_find #(.N(N), .SEL_W(SEL_W)) u_find (
        .mask      (find_mask),
        .cur       (ptr),
        .nxt       (nxt),
        .nxt_found (nxt_found),
        .low       (low),
        .low_found (low_found)
    );

    // Out-of-range sel falls through to zero data.
    always_comb begin
        sel_data = '0;
        ptr_data = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SEL_W'(k)) sel_data = d_in[k*W +: W];
            if (ptr == SEL_W'(k)) ptr_data = d_in[k*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            mask_q     <= '0;
            loop_q     <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!mode) begin
                        if (load) begin
                            out_data  <= sel_data;
                            out_ch    <= sel;
                            out_valid <= 1'b1;
                        end
                    end else begin
                        if (accept) out_valid <= 1'b0;
                        if (start) begin
                            mask_q <= skip_mask;
                            loop_q <= loop;
                            if (low_found) begin
                                ptr   <= low;
                                state <= SCAN;
                                busy  <= 1'b1;
                            end else begin
                                frame_done <= 1'b1;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end else if (load) begin
                        out_data  <= ptr_data;
                        out_ch    <= ptr;
                        out_valid <= 1'b1;
                        if (nxt_found) begin
                            ptr <= nxt;
                        end else if (loop_q) begin
                            ptr        <= low;
                            frame_done <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        out_valid  <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/tdm_channel_scanner.md
Name: tdm_channel_scanner

Overview:
Parametrised successor to the team's 16:1 single-bit multiplexer. Selects one W-bit channel out of N packed input channels and presents it on a registered output with a valid/ready handshake. It has two modes. Manual mode is a registered mux driven by sel. Auto-scan mode sequences through all unmasked channels, once or looping. It sits between parallel sensor/data lanes and a serial consumer (UART formatter, display driver).

Parameters:
W, 4, data width per channel (>=1)
N, 16, number of channels (>=2, need not be a power of two)
SEL_W, $clog2(N), channel index width (derived; do not override)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
d_in  input  N*W  packed channels; channel k = d_in[k*W +: W]
mode  input  1  0 = manual, 1 = auto-scan; sampled in IDLE only
sel  input  SEL_W  manual-mode channel index
skip_mask  input  N  bit k = 1 excludes channel k from auto-scan; latched at start
loop  input  1  1 = auto-scan repeats frames until abort; latched at start
start  input  1  single-cycle pulse; begins auto-scan when IDLE and mode=1
abort  input  1  terminates auto-scan
out_data  output  W  selected channel sample (registered)
out_ch  output  SEL_W  index of the channel in out_data
out_valid  output  1  out_data/out_ch hold a sample
out_ready  input  1  consumer accepts when out_valid && out_ready
busy  output  1  1 in SCAN or DRAIN
frame_done  output  1  one-cycle pulse at end of each auto-scan frame

Behaviour:
- Reset (rst=1 at a clock edge) clears out_data, out_ch, out_valid, busy, frame_done and the scan pointer, and sets state IDLE. Reset mid-scan discards any pending sample.
- Output register loads ("load slot") when !out_valid || out_ready. While out_valid && !out_ready, out_data and out_ch are held bit-stable.
- d_in is sampled live at the load cycle, not at frame start.
- FSM states:
  - IDLE:
    - mode=0: every load slot captures channel sel and sets out_valid=1. Latency is 1 clock from sel/d_in to output.
    - If sel >= N: out_data=0, out_ch=sel.
    - mode=1: out_valid is deasserted when the pending sample is accepted, and no new loads occur.
    - start && mode=1 latches skip_mask and loop, then sets ptr = lowest unmasked index and goes to SCAN.
    - If all channels are masked: no beats. frame_done pulses on the next cycle and the FSM stays in IDLE.
  - SCAN: each load slot captures channel ptr, then advances ptr to the next higher unmasked index.
    - No higher unmasked index and loop=0: go to DRAIN.
    - No higher unmasked index and loop=1: wrap ptr to the lowest unmasked index and pulse frame_done in the cycle after the last channel of the frame is loaded.
  - DRAIN: waits until the final sample is accepted, pulses frame_done in the cycle after acceptance, then returns to IDLE.
- Ignored inputs:
  - start is ignored while busy.
  - Changes to mode, skip_mask and loop are ignored while busy.
- abort:
  - In SCAN or DRAIN, abort forces IDLE on the next edge, clears out_valid and suppresses frame_done.
  - In IDLE, abort has no effect.
  - abort has priority over a simultaneous load or acceptance.
- Simultaneous accept and load in the same cycle is legal, giving full throughput of one sample per clock with out_ready held high.
- Channel order within a frame is strictly ascending. Each unmasked channel appears exactly once per frame.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, SCAN=2'd1, DRAIN=2'd2
  - a clog2 helper function
- One sub-module: ch_next_find.
  - Combinational priority finder.
  - Inputs: mask, current index.
  - Outputs: next unmasked index above current, lowest unmasked index, found flags.
  - Reused for both the start and advance paths.

Test Plan:
- Manual mode, W=4, N=16: d_in=64'h0123456789ABCDEF, out_ready=1, sel=4 -> out_data=4'hB, out_ch=4, one clock later; sel=9 -> out_data=4'h6.
- Auto single frame: skip_mask=16'h00F0, loop=0, out_ready=1, start pulse -> 12 beats with out_ch 0,1,2,3,8..15 on consecutive clocks; frame_done pulses once; busy falls; out_valid=0 afterwards.
- Back-pressure: auto scan with out_ready low for 5 clocks at out_ch=2 -> out_data/out_ch held stable; no channel skipped or duplicated; total 12 beats.
- Loop + abort: skip_mask=16'hFFFC, loop=1 -> out_ch sequence 0,1,0,1,...; frame_done after every second beat; abort -> IDLE next clock, out_valid=0.
- All masked: skip_mask=16'hFFFF, start -> zero beats, frame_done single pulse, busy stays 0.
- Reset mid-scan: rst asserted at out_ch=5 -> all outputs 0 next edge; a subsequent start restarts from channel 0.
